// File: rtl/cim_pkg.sv
// Shared definitions for the CIM macro controller: state encoding, lane
// geometry and the fct3 op codes the core uses to address the CIM engine.
package cim_pkg;

    localparam int LANE_W     = 8;
    localparam int NLANES     = 4;
    localparam int NACC       = 16;
    localparam int ACC_W      = 32;
    localparam int LANE_CNT_W = $clog2(NLANES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } cim_state_e;

    // fct3 encodings of the CIM custom instruction, as decoded by the core
    localparam logic [2:0] CIM_FCT3_WRITE   = 3'b000;
    localparam logic [2:0] CIM_FCT3_COMPUTE = 3'b001;
    localparam logic [2:0] CIM_FCT3_REG_RD  = 3'b010;
    localparam logic [2:0] CIM_FCT3_REG_RST = 3'b011;

endpackage

// File: rtl/cim_mac_lane.sv
// One MAC lane: signed 8x8 multiply, product sign-extended to accumulator width.
module cim_mac_lane
    import cim_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] w,
    output logic [ACC_W-1:0]  prod
);

    logic signed [2*LANE_W-1:0] p16;

    assign p16  = $signed(a) * $signed(w);
    assign prod = {{(ACC_W-2*LANE_W){p16[2*LANE_W-1]}}, p16};

endmodule

// File: rtl/cim_macro_ctrl.sv
// CIM macro controller: weight array, 16 accumulators and a 4-cycle serial
// signed MAC engine driven by the darkriscv CIM strobes.
//
// Handshake: the core holds its request strobes (write / cim+partial_sum /
// cim+reset_output) steady until the instruction retires. busy is the only
// back-pressure: while it is high the core is halted and keeps the request
// held. A compute raises busy in its first cycle, so the request is taken
// exactly once; the one-cycle DONE state swallows the still-held request
// while the core retires it.
module cim_macro_ctrl
    import cim_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int ACC_SEL_LSB = 28
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        write,
    input  logic        cim,
    input  logic        partial_sum,
    input  logic        reset_output,
    input  logic [3:0]  output_reg,
    input  logic [31:0] address,
    input  logic [31:0] input_data,
    output logic [31:0] cim_output,
    output logic        busy,
    output cim_state_e  state_dbg
);

    localparam int DEPTH = 2**ADDR_W;

    logic [ACC_W-1:0]      mem   [DEPTH];
    logic [ACC_W-1:0]      acc_q [NACC];
    cim_state_e            state_q;
    logic [LANE_CNT_W-1:0] lane_q;
    logic [ACC_W-1:0]      psum_q;
    logic [ACC_W-1:0]      a_q;
    logic [ACC_W-1:0]      w_q;
    logic [3:0]            sel_q;

    logic [ADDR_W-1:0]     row;
    logic [3:0]            sel;
    logic                  req_compute;
    logic                  req_clear;
    logic                  req_read_acc;
    logic [LANE_W-1:0]     a_lane;
    logic [LANE_W-1:0]     w_lane;
    logic [ACC_W-1:0]      prod;
    logic                  addr_unused;

    assign row          = address[ADDR_W-1:0];
    assign sel          = address[ACC_SEL_LSB+3:ACC_SEL_LSB];
    assign addr_unused  = ^address;
    assign req_compute  = cim && partial_sum;
    assign req_clear    = cim && reset_output;
    assign req_read_acc = cim && !partial_sum && !reset_output;

    assign a_lane = a_q[LANE_W*int'(lane_q) +: LANE_W];
    assign w_lane = w_q[LANE_W*int'(lane_q) +: LANE_W];

    cim_mac_lane u_mac_lane (
        .a    (a_lane),
        .w    (w_lane),
        .prod (prod)
    );

    // Stall the core from the very first cycle of a compute through the last lane
    assign busy = RES_N && ((state_q == ST_MAC) || ((state_q == ST_IDLE) && req_compute));

    assign state_dbg = state_q;

    // Read mux: accumulator read for a plain CIM register read, weight row otherwise
    assign cim_output = req_read_acc ? acc_q[output_reg] : mem[row];

    // Weight array write port; not reset, only written while idle
    always_ff @(posedge CLK) begin
        if (write && (state_q == ST_IDLE)) begin
            mem[row] <= input_data;
        end
    end

    // Control FSM, lane sequencing and accumulator updates
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            psum_q  <= '0;
            a_q     <= '0;
            w_q     <= '0;
            sel_q   <= '0;
            for (int i = 0; i < NACC; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_clear) begin
                        for (int i = 0; i < NACC; i++) begin
                            acc_q[i] <= '0;
                        end
                    end else if (req_compute) begin
                        a_q     <= input_data;
                        w_q     <= mem[row];
                        sel_q   <= sel;
                        psum_q  <= '0;
                        lane_q  <= '0;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    psum_q <= psum_q + prod;
                    lane_q <= lane_q + 1'b1;
                    if (lane_q == LANE_CNT_W'(NLANES-1)) begin
                        // fold the final lane product in directly
                        acc_q[sel_q] <= acc_q[sel_q] + psum_q + prod;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cim_macro_ctrl.sv
// Bench for cim_macro_ctrl: directed vectors, expected read-back values pushed
// to a queue by the driver and popped by a negedge monitor.
module tb_cim_macro_ctrl;
    import cim_pkg::*;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RES_N = 1'b0;
    logic        write = 1'b0;
    logic        cim = 1'b0;
    logic        partial_sum = 1'b0;
    logic        reset_output = 1'b0;
    logic [3:0]  output_reg = 4'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] input_data = 32'd0;
    logic [31:0] cim_output;
    logic        busy;
    cim_state_e  state_dbg;

    always #5 CLK = ~CLK;

    cim_macro_ctrl #(.ADDR_W(6), .ACC_SEL_LSB(28)) dut (
        .CLK          (CLK),
        .RES_N        (RES_N),
        .write        (write),
        .cim          (cim),
        .partial_sum  (partial_sum),
        .reset_output (reset_output),
        .output_reg   (output_reg),
        .address      (address),
        .input_data   (input_data),
        .cim_output   (cim_output),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_valid = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // monitor: compare cim_output mid-cycle whenever a read is presented
    always @(negedge CLK) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got 0x%08h expected <none queued>", cim_output);
            end else begin
                check(name_q.pop_front(), cim_output, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        write = 1'b0; cim = 1'b0; partial_sum = 1'b0; reset_output = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        idle_inputs();
        write = 1'b1; address = addr; input_data = data;
        tick();
        idle_inputs();
    endtask

    task automatic rd_acc(input logic [3:0] idx, input logic [31:0] exp, input string nm);
        idle_inputs();
        cim = 1'b1; output_reg = idx;
        exp_q.push_back(exp); name_q.push_back(nm);
        rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        idle_inputs();
    endtask

    task automatic rd_mem(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        idle_inputs();
        address = addr;
        exp_q.push_back(exp); name_q.push_back(nm);
        rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
    endtask

    // request held from T through DONE (T+5), released at T+6
    task automatic do_compute(input logic [31:0] addr, input logic [31:0] acts);
        idle_inputs();
        cim = 1'b1; partial_sum = 1'b1; address = addr; input_data = acts;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("cmp_busy", 32'(busy), (i < 5) ? 32'd1 : 32'd0);
            if (i == 5) check("cmp_done_state", 32'(state_dbg), 32'(ST_DONE));
            tick();
        end
        idle_inputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // 1. reset and read back all accumulators
        repeat (3) tick();
        @(negedge CLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        RES_N = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) rd_acc(4'(i), 32'h0, "acc_after_reset");
        @(negedge CLK);
        check("idle_busy", 32'(busy), 32'd0);

        // 2. weight write / read, row wrap on upper address bits
        write_word(32'd5, 32'h0102_0304);
        rd_mem(32'd5, 32'h0102_0304, "mem_row5");
        rd_mem(32'h0000_0045, 32'h0102_0304, "mem_row5_alias45");
        rd_mem(32'hFFFF_FFC5, 32'h0102_0304, "mem_row5_aliasC5");

        // 3. signed dot product: weights (1,-2,2,-1), acts (2,3,4,5) -> -1 into ACC[2]
        write_word(32'd3, 32'hFF02_FE01);
        do_compute(32'h2000_0003, 32'h0504_0302);
        rd_acc(4'd2, 32'hFFFF_FFFF, "acc2_signed_dot");

        // 4. accumulate across zero: 3 x (-128*127*4) then 4 x (127*127*4), then (-128)*(-128)*4
        write_word(32'd10, 32'h8080_8080);
        write_word(32'd11, 32'h7F7F_7F7F);
        repeat (3) do_compute(32'h7000_000A, 32'h7F7F_7F7F);
        rd_acc(4'd7, 32'hFFFD_0600, "acc7_negative");
        repeat (4) do_compute(32'h7000_000B, 32'h7F7F_7F7F);
        rd_acc(4'd7, 32'h0000_F610, "acc7_wrapped_positive");
        do_compute(32'h7000_000A, 32'h8080_8080);
        rd_acc(4'd7, 32'h0001_F610, "acc7_min_times_min");

        // accumulator clear
        idle_inputs();
        cim = 1'b1; reset_output = 1'b1;
        @(negedge CLK);
        check("clear_busy", 32'(busy), 32'd0);
        tick();
        idle_inputs();
        rd_acc(4'd7, 32'h0, "acc7_cleared");
        rd_acc(4'd2, 32'h0, "acc2_cleared");

        // 5a. held request through DONE accumulates once: 80*1 + (-16)*(-1) = 96
        do_compute(32'h4000_0003, 32'hF000_0050);
        rd_acc(4'd4, 32'h0000_0060, "acc4_single_held");

        // 5b. request still held at T+6 starts a second compute
        idle_inputs();
        cim = 1'b1; partial_sum = 1'b1; address = 32'h4000_0003; input_data = 32'hF000_0050;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            check("b2b_busy", 32'(busy), ((i < 5) || (i >= 6 && i <= 10)) ? 32'd1 : 32'd0);
            tick();
            if (i == 6) idle_inputs();
        end
        rd_acc(4'd4, 32'h0000_0120, "acc4_back_to_back");

        // 6. reset mid-compute
        write_word(32'd20, 32'h1234_5678);
        do_compute(32'h9000_0014, 32'h0000_0001);
        rd_acc(4'd9, 32'h0000_0078, "acc9_before_abort");
        idle_inputs();
        cim = 1'b1; partial_sum = 1'b1; address = 32'h9000_0014; input_data = 32'h0101_0101;
        tick();
        tick();
        RES_N = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        idle_inputs();
        tick();
        tick();
        RES_N = 1'b1;
        tick();
        rd_acc(4'd9, 32'h0, "acc9_after_abort");
        rd_acc(4'd4, 32'h0, "acc4_after_abort");
        rd_mem(32'd20, 32'h1234_5678, "mem_row20_kept");
        rd_mem(32'd3, 32'hFF02_FE01, "mem_row3_kept");
        rd_mem(32'd5, 32'h0102_0304, "mem_row5_kept");

        repeat (3) tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
